// File: rtl/bin_line_window.sv
// bin_line_window: binarised multi-line window for column filtering.
// Each pixel goes through an RGB888-to-luma conversion and is compared with
// threshold. The resulting bit goes into one of NUM_LINES 1-bit line buffers.
// The other buffers are read at the same column. Together they form a vertical
// window of NUM_LINES-1 completed lines, which is reduced to one bit by the
// mode-selected column filter.
//
// Ports
//   bit_clk      single clock, rising edge
//   reset        asynchronous, active high
//   pixel        RGB888 input (R[23:16] G[15:8] B[7:0])
//   pix_valid    pixel / x_cont valid
//   h_sync       high while a line is active; falling edge ends a line
//   frame_start  one-cycle pulse that restarts line counting
//   x_cont       current pixel column
//   threshold    luma threshold (bit = Y > threshold)
//   mode         column filter: 0 newest, 1 OR, 2 AND, 3 majority
//   taps         column window, bit 0 oldest line, MSB newest line
//   col_out      filtered column bit
//   out_valid    taps / col_out / x_out valid (2-cycle latency)
//   x_out        column that taps / col_out belong to
//   win_ready    NUM_LINES-1 complete lines held this frame

module bin_line_buf #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic          wbit,
  output logic          rbit
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Line storage is never reset; unwritten columns keep stale data.
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[IW'(addr)] <= wbit;
    if (re) rbit <= mem[IW'(addr)];
  end
endmodule

module bin_line_window #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_W     = 10
) (
  input  logic                 bit_clk,
  input  logic                 reset,
  input  logic [23:0]          pixel,
  input  logic                 pix_valid,
  input  logic                 h_sync,
  input  logic                 frame_start,
  input  logic [ADDR_W-1:0]    x_cont,
  input  logic [7:0]           threshold,
  input  logic [1:0]           mode,
  output logic [NUM_LINES-2:0] taps,
  output logic                 col_out,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    x_out,
  output logic                 win_ready
);
  localparam int TW     = NUM_LINES - 1;
  localparam int WR_W   = $clog2(NUM_LINES);
  localparam int STAGES = 2;

  if ((2 ** ADDR_W) < LINE_WIDTH || NUM_LINES < 3 || NUM_LINES > 8) begin : g_bad_params
    $error("bin_line_window: illegal NUM_LINES/LINE_WIDTH/ADDR_W");
  end

  // Input stage: luma and threshold
  logic [15:0] luma;
  logic        wbit, in_range, qual, acc;

  // Each term is truncated on its own before the sum; the maximum is 71+151+31 = 253.
  assign luma = ((16'd9  * 16'(pixel[23:16])) >> 5)
              + ((16'd19 * 16'(pixel[15:8]))  >> 5)
              + ((16'd4  * 16'(pixel[7:0]))   >> 5);
  assign wbit     = luma > 16'(threshold);
  assign in_range = 32'(x_cont) < 32'(LINE_WIDTH);
  // The reset gate stops writes while reset is held, even though the buffers themselves are never reset.
  assign qual     = pix_valid & h_sync & ~reset;
  assign acc      = qual & in_range;

  // Line bookkeeping
  logic            hs_q;
  logic            h_fall;
  logic [WR_W-1:0] wr, fill;

  assign h_fall    = hs_q & ~h_sync;
  assign win_ready = (fill == WR_W'(TW));

  always_ff @(posedge bit_clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      wr   <= '0;
      fill <= '0;
    end else begin
      hs_q <= h_sync;
      if (frame_start) begin          // takes priority over a coincident line end
        wr   <= '0;
        fill <= '0;
      end else if (h_fall) begin
        wr <= (wr == WR_W'(NUM_LINES - 1)) ? '0 : wr + 1'b1;
        if (fill != WR_W'(TW)) fill <= fill + 1'b1;
      end
    end
  end

  // Line buffers: one writes, all the others read at the same column
  logic [NUM_LINES-1:0] rd_s1;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    bin_line_buf #(.DEPTH(LINE_WIDTH), .AW(ADDR_W)) u_buf (
      .clk  (bit_clk),
      .we   (acc & (wr == WR_W'(i))),
      .re   (acc & (wr != WR_W'(i))),
      .addr (x_cont),
      .wbit (wbit),
      .rbit (rd_s1[i])
    );
  end

  // Stage 1: the read data is registered inside the buffers; the side info travels alongside it
  logic [STAGES:1]    vld_pipe;
  logic [WR_W-1:0]    wr_s1;
  logic [1:0]         mode_s1;
  logic [ADDR_W-1:0]  x_s1;
  logic [TW-1:0]      tap_nx;
  logic               col_nx;

  // Rotate so that buffer WR+1 (the oldest line) lands at bit 0. Doubling the
  // vector makes the modulo-NUM_LINES wrap free.
  assign tap_nx = TW'({rd_s1, rd_s1} >> (32'(wr_s1) + 32'd1));

  always_comb begin
    col_nx = 1'b0;
    case (mode_s1)
      2'd0:    col_nx = tap_nx[TW-1];
      2'd1:    col_nx = |tap_nx;
      2'd2:    col_nx = &tap_nx;
      default: col_nx = ($countones(tap_nx) > (TW / 2));
    endcase
  end

  // Stage 2: registered outputs, held while not valid
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge bit_clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      wr_s1    <= '0;
      mode_s1  <= '0;
      x_s1     <= '0;
      taps     <= '0;
      col_out  <= 1'b0;
      x_out    <= '0;
    end else begin
      vld_pipe <= frame_start ? '0 : {vld_pipe[STAGES-1:1], qual & win_ready};
      if (qual) begin
        wr_s1   <= wr;
        mode_s1 <= mode;
        x_s1    <= x_cont;
      end
      if (vld_pipe[1] & ~frame_start) begin
        taps    <= tap_nx;
        col_out <= col_nx;
        x_out   <= x_s1;
      end
    end
  end
endmodule
